attack_engine: RTL and testbench

- Parametrised successor to the single-punch knockback logic. Resolves two attack types (punch, kick) for both fighters through per-player attack state machines with windup, active and recover phases.
- Performs a one-hit-per-attack check during the active phase, drives a signed, decaying knockback velocity per player, and outputs one-frame hit pulses.
- Sits between the keyboard keycode bus and the player motion/sprite blocks. Clocked by frame_clk.

---
 rtl/fight_pkg.sv | 29 ++
 rtl/attack_fsm.sv | 105 ++++++++++
 rtl/attack_engine.sv | 164 ++++++++++++++++
 tb/tb_attack_engine.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fight_pkg.sv
// Shared types and keycodes for the two-player attack engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fight_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WINDUP  = 2'd1,
        ACTIVE  = 2'd2,
        RECOVER = 2'd3
    } atk_state_t;

    localparam int CNT_W = 8;

    localparam logic [7:0] P1_PUNCH_KEY = 8'h06;
    localparam logic [7:0] P1_KICK_KEY  = 8'h1B;
    localparam logic [7:0] P2_PUNCH_KEY = 8'h11;
    localparam logic [7:0] P2_KICK_KEY  = 8'h10;
    localparam logic [7:0] P1_BLOCK_KEY = 8'h16;
    localparam logic [7:0] P2_BLOCK_KEY = 8'h51;

    // Step a knockback velocity one unit toward zero.
    function automatic logic signed [31:0] kb_decay(input logic signed [31:0] v);
        if (v > 0)      return v - 32'sd1;
        else if (v < 0) return v + 32'sd1;
        else            return v;
    endfunction

endpackage

// File: rtl/attack_fsm.sv
// Per-player attack phase machine: edge-detected start, windup/active/recover timing, one-hit latch.
// Latency: phase and flags change on the frame edge after the triggering input.
// Backpressure: none; key presses outside IDLE are simply ignored.
module attack_fsm
    import fight_pkg::*;
#(
    parameter int WINDUP_FRAMES  = 2,
    parameter int ACTIVE_FRAMES  = 3,
    parameter int RECOVER_FRAMES = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       punch_pressed,
    input  logic       kick_pressed,
    input  logic       force_recover,
    input  logic       hit_landed,
    output atk_state_t state,
    output logic       atk_kick,
    output logic       hit_done
);

    localparam logic [CNT_W-1:0] WIND_INIT = CNT_W'(WINDUP_FRAMES - 1);
    localparam logic [CNT_W-1:0] ACT_INIT  = CNT_W'(ACTIVE_FRAMES - 1);
    localparam logic [CNT_W-1:0] REC_INIT  = CNT_W'(RECOVER_FRAMES - 1);

    atk_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             atk_kick_q, atk_kick_d;
    logic             hit_done_q, hit_done_d;
    logic             punch_prev_q, punch_prev_d;
    logic             kick_prev_q, kick_prev_d;
    logic             punch_rise, kick_rise;

    // State register: phase, counter, attack type, hit latch and press history.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            atk_kick_q   <= 1'b0;
            hit_done_q   <= 1'b0;
            punch_prev_q <= 1'b0;
            kick_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            atk_kick_q   <= atk_kick_d;
            hit_done_q   <= hit_done_d;
            punch_prev_q <= punch_prev_d;
            kick_prev_q  <= kick_prev_d;
        end
    end

    // Next-state: start on a fresh press, count down each phase, forced recover overrides.
    always_comb begin
        punch_rise   = punch_pressed & ~punch_prev_q;
        kick_rise    = kick_pressed & ~kick_prev_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        atk_kick_d   = atk_kick_q;
        hit_done_d   = hit_done_q | hit_landed;
        punch_prev_d = punch_pressed;
        kick_prev_d  = kick_pressed;
        case (state_q)
            IDLE: begin
                if (punch_rise || kick_rise) begin
                    state_d    = WINDUP;
                    cnt_d      = WIND_INIT;
                    atk_kick_d = ~punch_rise;  // punch wins a simultaneous press
                    hit_done_d = 1'b0;
                end
            end
            WINDUP: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else begin
                    state_d = ACTIVE;
                    cnt_d   = ACT_INIT;
                end
            end
            ACTIVE: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else begin
                    state_d = RECOVER;
                    cnt_d   = REC_INIT;
                end
            end
            default: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else             state_d = IDLE;
            end
        endcase
        // Being struck during windup cancels the attack straight into recovery.
        if (force_recover && state_q == WINDUP) begin
            state_d = RECOVER;
            cnt_d   = REC_INIT;
        end
    end

    // Outputs come straight from the registers.
    always_comb begin
        state    = state_q;
        atk_kick = atk_kick_q;
        hit_done = hit_done_q;
    end

endmodule

// File: rtl/attack_engine.sv
// Two-player punch/kick resolver: phase FSMs, one-hit-per-attack check, decaying signed knockback.
// Latency: hit pulse and knockback appear on the frame edge that samples the ACTIVE attacker.
// Backpressure: none. Optional block support via ATTACK_BLOCK_EN (halves knockback for an idle blocker).
module attack_engine
    import fight_pkg::*;
#(
    parameter int NUM_KEYS       = 4,
    parameter int WINDUP_FRAMES  = 2,
    parameter int ACTIVE_FRAMES  = 3,
    parameter int RECOVER_FRAMES = 6,
    parameter int PUNCH_RANGE    = 120,
    parameter int KICK_RANGE     = 150,
    parameter int PUNCH_YOFF     = 30,
    parameter int KICK_YOFF      = 60,
    parameter int KB_SPEED       = 8
) (
    input  logic                           frame_clk,
    input  logic                           Reset,
    input  logic [NUM_KEYS-1:0][7:0]       keycodes,
    input  logic signed [31:0]             P1Xpos,
    input  logic signed [31:0]             P1Ypos,
    input  logic signed [31:0]             P2Xpos,
    input  logic signed [31:0]             P2Ypos,
    output logic signed [31:0]             p1_knockback,
    output logic signed [31:0]             p2_knockback,
    output logic                           p1_hit,
    output logic                           p2_hit,
    output logic [1:0]                     p1_state,
    output logic [1:0]                     p2_state,
    output logic                           p1_atk_kick,
    output logic                           p2_atk_kick
);

    localparam logic signed [31:0] KB_FULL = KB_SPEED;

    logic p1_punch_prs, p1_kick_prs, p2_punch_prs, p2_kick_prs;
    logic p1_blocking, p2_blocking;
    atk_state_t p1_st, p2_st;
    logic p1_kick, p2_kick, p1_done, p2_done;
    logic p1_strikes, p2_strikes;
    logic signed [31:0] xdiff, xdist, p1_range, p2_range, p1_yoff, p2_yoff;
    logic signed [31:0] p1_kb_amt, p2_kb_amt;

    logic signed [31:0] p1_kb_q, p1_kb_d, p2_kb_q, p2_kb_d;
    logic               p1_hit_q, p1_hit_d, p2_hit_q, p2_hit_d;

    // Scan every keycode slot for each player's keys.
    always_comb begin
        p1_punch_prs = 1'b0;
        p1_kick_prs  = 1'b0;
        p2_punch_prs = 1'b0;
        p2_kick_prs  = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (keycodes[i] == P1_PUNCH_KEY) p1_punch_prs = 1'b1;
            if (keycodes[i] == P1_KICK_KEY)  p1_kick_prs  = 1'b1;
            if (keycodes[i] == P2_PUNCH_KEY) p2_punch_prs = 1'b1;
            if (keycodes[i] == P2_KICK_KEY)  p2_kick_prs  = 1'b1;
        end
    end

`ifdef ATTACK_BLOCK_EN
    localparam logic signed [31:0] KB_HALF = KB_SPEED >>> 1;
    logic p1_blk_prs, p2_blk_prs;

    // A blocker must hold its key while standing idle.
    always_comb begin
        p1_blk_prs = 1'b0;
        p2_blk_prs = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (keycodes[i] == P1_BLOCK_KEY) p1_blk_prs = 1'b1;
            if (keycodes[i] == P2_BLOCK_KEY) p2_blk_prs = 1'b1;
        end
        p1_blocking = p1_blk_prs && (p1_st == IDLE);
        p2_blocking = p2_blk_prs && (p2_st == IDLE);
        p1_kb_amt   = p1_blocking ? KB_HALF : KB_FULL;
        p2_kb_amt   = p2_blocking ? KB_HALF : KB_FULL;
    end
`else
    // Blocking is not built in: every hit delivers full knockback.
    always_comb begin
        p1_blocking = 1'b0;
        p2_blocking = 1'b0;
        p1_kb_amt   = KB_FULL;
        p2_kb_amt   = KB_FULL;
    end
`endif

    attack_fsm #(
        .WINDUP_FRAMES (WINDUP_FRAMES),
        .ACTIVE_FRAMES (ACTIVE_FRAMES),
        .RECOVER_FRAMES(RECOVER_FRAMES)
    ) u_p1_fsm (
        .clk          (frame_clk),
        .reset        (Reset),
        .punch_pressed(p1_punch_prs),
        .kick_pressed (p1_kick_prs),
        .force_recover(p2_strikes),
        .hit_landed   (p1_strikes),
        .state        (p1_st),
        .atk_kick     (p1_kick),
        .hit_done     (p1_done)
    );

    attack_fsm #(
        .WINDUP_FRAMES (WINDUP_FRAMES),
        .ACTIVE_FRAMES (ACTIVE_FRAMES),
        .RECOVER_FRAMES(RECOVER_FRAMES)
    ) u_p2_fsm (
        .clk          (frame_clk),
        .reset        (Reset),
        .punch_pressed(p2_punch_prs),
        .kick_pressed (p2_kick_prs),
        .force_recover(p1_strikes),
        .hit_landed   (p2_strikes),
        .state        (p2_st),
        .atk_kick     (p2_kick),
        .hit_done     (p2_done)
    );

    // Hit check for each attacker, then knockback reload or one-step decay.
    always_comb begin
        xdiff      = P1Xpos - P2Xpos;
        xdist      = xdiff[31] ? -xdiff : xdiff;
        p1_range   = p1_kick ? KICK_RANGE : PUNCH_RANGE;
        p2_range   = p2_kick ? KICK_RANGE : PUNCH_RANGE;
        p1_yoff    = p1_kick ? KICK_YOFF : PUNCH_YOFF;
        p2_yoff    = p2_kick ? KICK_YOFF : PUNCH_YOFF;
        p1_strikes = (p1_st == ACTIVE) && !p1_done &&
                     (xdist < p1_range) && ((P1Ypos + p1_yoff) > P2Ypos);
        p2_strikes = (p2_st == ACTIVE) && !p2_done &&
                     (xdist < p2_range) && ((P2Ypos + p2_yoff) > P1Ypos);
        p1_hit_d   = p2_strikes;
        p2_hit_d   = p1_strikes;
        p1_kb_d    = kb_decay(p1_kb_q);
        p2_kb_d    = kb_decay(p2_kb_q);
        if (p2_strikes) p1_kb_d = (P1Xpos >= P2Xpos) ? p1_kb_amt : -p1_kb_amt;
        if (p1_strikes) p2_kb_d = (P2Xpos >= P1Xpos) ? p2_kb_amt : -p2_kb_amt;
    end

    // Knockback and hit-pulse registers.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            p1_kb_q  <= '0;
            p2_kb_q  <= '0;
            p1_hit_q <= 1'b0;
            p2_hit_q <= 1'b0;
        end else begin
            p1_kb_q  <= p1_kb_d;
            p2_kb_q  <= p2_kb_d;
            p1_hit_q <= p1_hit_d;
            p2_hit_q <= p2_hit_d;
        end
    end

    assign p1_knockback = p1_kb_q;
    assign p2_knockback = p2_kb_q;
    assign p1_hit       = p1_hit_q;
    assign p2_hit       = p2_hit_q;
    assign p1_state     = p1_st;
    assign p2_state     = p2_st;
    assign p1_atk_kick  = p1_kick;
    assign p2_atk_kick  = p2_kick;

endmodule

// File: tb/tb_attack_engine.sv
// Directed scoreboard bench for attack_engine: expectations are queued per frame edge
// when stimulus is driven and checked one time unit after that edge.
// Covers reset, hit timing, decay, range/height misses, kick, hold, trade, cancel, mid-attack reset.
module tb_attack_engine;

    logic frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    logic                     Reset;
    logic [3:0][7:0]          keycodes;
    logic signed [31:0]       P1Xpos, P1Ypos, P2Xpos, P2Ypos;
    logic signed [31:0]       p1_knockback, p2_knockback;
    logic                     p1_hit, p2_hit;
    logic [1:0]               p1_state, p2_state;
    logic                     p1_atk_kick, p2_atk_kick;

    attack_engine dut (
        .frame_clk   (frame_clk),
        .Reset       (Reset),
        .keycodes    (keycodes),
        .P1Xpos      (P1Xpos),
        .P1Ypos      (P1Ypos),
        .P2Xpos      (P2Xpos),
        .P2Ypos      (P2Ypos),
        .p1_knockback(p1_knockback),
        .p2_knockback(p2_knockback),
        .p1_hit      (p1_hit),
        .p2_hit      (p2_hit),
        .p1_state    (p1_state),
        .p2_state    (p2_state),
        .p1_atk_kick (p1_atk_kick),
        .p2_atk_kick (p2_atk_kick)
    );

    localparam int S_P1KB = 0, S_P2KB = 1, S_P1HIT = 2, S_P2HIT = 3;
    localparam int S_P1ST = 4, S_P2ST = 5, S_P1AK = 6, S_P2AK = 7;

    typedef struct {
        int                 frame;
        int                 sig;
        logic signed [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   bad    = 0;
    int   edge_n = -1;

    function automatic logic signed [31:0] observe(input int sig);
        case (sig)
            S_P1KB:  return p1_knockback;
            S_P2KB:  return p2_knockback;
            S_P1HIT: return {31'b0, p1_hit};
            S_P2HIT: return {31'b0, p2_hit};
            S_P1ST:  return {30'b0, p1_state};
            S_P2ST:  return {30'b0, p2_state};
            S_P1AK:  return {31'b0, p1_atk_kick};
            default: return {31'b0, p2_atk_kick};
        endcase
    endfunction

    function automatic string sig_name(input int sig);
        case (sig)
            S_P1KB:  return "p1_knockback";
            S_P2KB:  return "p2_knockback";
            S_P1HIT: return "p1_hit";
            S_P2HIT: return "p2_hit";
            S_P1ST:  return "p1_state";
            S_P2ST:  return "p2_state";
            S_P1AK:  return "p1_atk_kick";
            default: return "p2_atk_kick";
        endcase
    endfunction

    task automatic exp_at(input int f, input int s, input logic signed [31:0] v);
        exp_t e;
        e.frame = f;
        e.sig   = s;
        e.val   = v;
        sb.push_back(e);
    endtask

    // Advance one frame edge and retire every expectation due at it.
    task automatic step();
        exp_t               e;
        logic signed [31:0] o;
        @(posedge frame_clk);
        #1;
        edge_n++;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].frame == edge_n) begin
                e = sb[i];
                sb.delete(i);
                o = observe(e.sig);
                total++;
                assert (o === e.val) else begin
                    bad++;
                    $error("FAIL %s edge=%0d observed=%0d expected=%0d",
                           sig_name(e.sig), edge_n, o, e.val);
                end
            end
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        Reset    = 1'b1;
        keycodes = '0;
        step();
        Reset    = 1'b0;
    endtask

    task automatic exp_all_zero(input int f);
        for (int s = 0; s < 8; s++) exp_at(f, s, 0);
    endtask

    initial begin
        int b;
        Reset    = 1'b1;
        keycodes = '0;
        P1Xpos = 100; P2Xpos = 200; P1Ypos = 50; P2Ypos = 50;

        // Reset state.
        exp_all_zero(edge_n + 1);
        do_reset();

        // Punch hit: one-frame pulse, +8 knockback decaying to 0, full phase timing.
        b = edge_n + 1;
        exp_at(b, S_P1ST, 1);
        exp_at(b, S_P1AK, 0);
        exp_at(b + 1, S_P1ST, 1);
        exp_at(b + 2, S_P1ST, 2);
        exp_at(b + 2, S_P2HIT, 0);
        exp_at(b + 3, S_P2HIT, 1);
        exp_at(b + 3, S_P1HIT, 0);
        exp_at(b + 3, S_P1KB, 0);
        exp_at(b + 4, S_P2HIT, 0);
        for (int k = 3; k <= 11; k++) exp_at(b + k, S_P2KB, 11 - k);
        exp_at(b + 5, S_P1ST, 3);
        exp_at(b + 10, S_P1ST, 3);
        exp_at(b + 11, S_P1ST, 0);
        exp_at(b + 12, S_P2KB, 0);
        keycodes[2] = 8'h06;
        step();
        keycodes = '0;
        steps(13);

        // XDist 130: punch misses, kick connects.
        P2Xpos = 230;
        do_reset();
        b = edge_n + 1;
        exp_at(b + 3, S_P2HIT, 0);
        exp_at(b + 3, S_P2KB, 0);
        exp_at(b + 4, S_P2KB, 0);
        keycodes[0] = 8'h06;
        step();
        keycodes = '0;
        steps(12);
        b = edge_n + 1;
        exp_at(b, S_P1AK, 1);
        exp_at(b + 3, S_P2HIT, 1);
        exp_at(b + 3, S_P2KB, 8);
        keycodes[1] = 8'h1B;
        step();
        keycodes = '0;
        steps(4);

        // XDist exactly at punch range misses.
        P2Xpos = 220;
        do_reset();
        b = edge_n + 1;
        exp_at(b + 3, S_P2HIT, 0);
        exp_at(b + 3, S_P2KB, 0);
        keycodes[0] = 8'h06;
        step();
        keycodes = '0;
        steps(4);

        // Fist height equal to victim Y misses.
        P2Xpos = 200;
        P2Ypos = 80;
        do_reset();
        b = edge_n + 1;
        exp_at(b + 3, S_P2HIT, 0);
        keycodes[0] = 8'h06;
        step();
        keycodes = '0;
        steps(4);
        P2Ypos = 50;

        // P2 punch pushes P1 left; held key does not re-trigger.
        do_reset();
        b = edge_n + 1;
        exp_at(b, S_P2AK, 0);
        exp_at(b + 3, S_P1HIT, 1);
        exp_at(b + 3, S_P1KB, -8);
        exp_at(b + 4, S_P1KB, -7);
        exp_at(b + 11, S_P2ST, 0);
        exp_at(b + 11, S_P1KB, 0);
        exp_at(b + 12, S_P2ST, 0);
        exp_at(b + 15, S_P2ST, 0);
        exp_at(b + 20, S_P2ST, 0);
        exp_at(b + 20, S_P1HIT, 0);
        exp_at(b + 20, S_P1KB, 0);
        keycodes[0] = 8'h11;
        steps(21);
        keycodes = '0;
        step();

        // Trade: both punch on the same frame.
        do_reset();
        b = edge_n + 1;
        exp_at(b + 3, S_P1HIT, 1);
        exp_at(b + 3, S_P2HIT, 1);
        exp_at(b + 3, S_P1KB, -8);
        exp_at(b + 3, S_P2KB, 8);
        exp_at(b + 3, S_P1ST, 2);
        exp_at(b + 3, S_P2ST, 2);
        exp_at(b + 4, S_P1KB, -7);
        exp_at(b + 4, S_P2KB, 7);
        keycodes[0] = 8'h06;
        keycodes[1] = 8'h11;
        step();
        keycodes = '0;
        steps(5);

        // Windup cancel of P1, then reset mid-recover.
        do_reset();
        b = edge_n + 1;
        exp_at(b + 2, S_P2ST, 2);
        exp_at(b + 2, S_P1ST, 1);
        exp_at(b + 3, S_P1ST, 3);
        exp_at(b + 3, S_P1HIT, 1);
        exp_at(b + 3, S_P1KB, -8);
        exp_at(b + 5, S_P2HIT, 0);
        exp_at(b + 5, S_P2KB, 0);
        exp_at(b + 6, S_P1ST, 3);
        exp_at(b + 6, S_P2ST, 3);
        exp_at(b + 6, S_P1KB, -5);
        exp_all_zero(b + 7);
        keycodes[0] = 8'h11;
        step();
        keycodes = '0;
        step();
        keycodes[1] = 8'h06;
        step();
        keycodes = '0;
        steps(4);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        step();

`ifdef ATTACK_BLOCK_EN
        // Idle blocker takes half knockback but still gets the pulse.
        do_reset();
        b = edge_n + 1;
        exp_at(b + 3, S_P2HIT, 1);
        exp_at(b + 3, S_P2KB, 4);
        exp_at(b + 3, S_P2ST, 0);
        keycodes[3] = 8'h51;
        keycodes[2] = 8'h06;
        step();
        keycodes[2] = 8'h00;
        steps(4);
        keycodes = '0;
`endif

        // Any expectation never reached is a failure.
        foreach (sb[i]) begin
            total++;
            bad++;
            $display("FAIL %s never checked (frame=%0d expected=%0d)",
                     sig_name(sb[i].sig), sb[i].frame, sb[i].val);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
